// File: rtl/mig_pkg.sv
// Shared types and sizing helpers for the MIG truth-table sweeper.
// Node numbering: const0, then primary inputs, then gate outputs.
package mig_pkg;

  localparam int NW_MAX = 8;
  localparam int NODE_CONST0 = 0;
  localparam int NODE_X0 = 1;

  function automatic int node_g0(int n_inputs);
    return n_inputs + 1;
  endfunction

  function automatic int nw(int n_inputs, int n_gates);
    return $clog2(1 + n_inputs + n_gates);
  endfunction

  function automatic int gw(int n_gates);
    return (n_gates > 1) ? $clog2(n_gates) : 1;
  endfunction

  typedef struct packed {
    logic [NW_MAX-1:0] sel_a;
    logic [NW_MAX-1:0] sel_b;
    logic [NW_MAX-1:0] sel_c;
    logic [2:0]        inv;
  } gate_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_OUT
  } state_t;

endpackage

// File: rtl/mig_gate_eval.sv
// One majority gate: operand muxes over the nodes below it, complements, MAJ3.
// Only nodes visible on the port are selectable; anything else reads const0.
module mig_gate_eval
  import mig_pkg::*;
#(
  parameter int N_IN = 8
) (
  input  logic [N_IN-1:0] nodes,
  input  gate_cfg_t       cfg,
  output logic            y
);

  logic a;
  logic b;
  logic c;

  function automatic logic pick(
    input logic [N_IN-1:0]   v,
    input logic [NW_MAX-1:0] sel
  );
    logic r;
    r = 1'b0;
    for (int n = 0; n < N_IN; n++)
      if (sel == NW_MAX'(n)) r = v[n];
    return r;
  endfunction

  always_comb begin
    a = pick(nodes, cfg.sel_a) ^ cfg.inv[0];
    b = pick(nodes, cfg.sel_b) ^ cfg.inv[1];
    c = pick(nodes, cfg.sel_c) ^ cfg.inv[2];
    y = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/mig_tt_sweeper.sv
// Programmable MIG evaluator: sweeps every minterm once per cycle and
// streams the resulting truth table in WORD_W-bit words over valid/ready.
module mig_tt_sweeper
  import mig_pkg::*;
#(
  parameter  int N_INPUTS = 7,
  parameter  int N_GATES  = 8,
  parameter  int WORD_W   = 32,
  localparam int NW       = nw(N_INPUTS, N_GATES),
  localparam int GW       = gw(N_GATES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [GW-1:0]     cfg_gate,
  input  logic [3*NW-1:0]   cfg_sel,
  input  logic [2:0]        cfg_inv,
  input  logic              out_we,
  input  logic [NW-1:0]     out_sel,
  input  logic              out_inv,
  input  logic              start,
  output logic              busy,
  output logic [WORD_W-1:0] tt_data,
  output logic              tt_valid,
  output logic              tt_last,
  input  logic              tt_ready,
  output logic              done
);

  localparam int NG0 = node_g0(N_INPUTS);
  localparam int NN  = NG0 + N_GATES;
  localparam int LW  = $clog2(WORD_W);
  localparam logic [N_INPUTS:0] MT_LAST =
    (N_INPUTS + 1)'((1 << N_INPUTS) - 1);

  state_t            state;
  state_t            state_nx;
  gate_cfg_t         cfg_q [N_GATES];
  logic [NW-1:0]     out_sel_q;
  logic              out_inv_q;
  logic [N_INPUTS:0] mt;
  logic [WORD_W-2:0] sh;
  logic              last_q;
  logic              done_q;
  logic [NG0-1:0]    base;
  logic [NN-1:0]     all_nodes;
  logic              f;
  logic              idle;
  logic              word_end;
  logic              sweep_end;
  logic              accept;

  assign idle      = (state == ST_IDLE);
  assign accept    = (state == ST_OUT) && tt_ready;
  assign word_end  = &mt[LW-1:0];
  assign sweep_end = (mt == MT_LAST);

  always_comb begin
    base = '0;
    base[NODE_CONST0] = 1'b0;
    base[NODE_X0 +: N_INPUTS] = mt[N_INPUTS-1:0];
  end

  // Each stage sees only the nodes below it, so the chain is acyclic.
  for (genvar g = 0; g < N_GATES; g++) begin : g_gate
    localparam int LIM = NG0 + g;
    logic [LIM-1:0] ins;
    logic [LIM:0]   nodes;
    logic           y;
    if (g == 0) begin : g_first
      assign ins = base;
    end else begin : g_next
      assign ins = g_gate[g-1].nodes;
    end
    mig_gate_eval #(
      .N_IN (LIM)
    ) u_gate (
      .nodes (ins),
      .cfg   (cfg_q[g]),
      .y     (y)
    );
    assign nodes = {y, ins};
  end

  assign all_nodes = g_gate[N_GATES-1].nodes;

  always_comb begin
    f = 1'b0;
    for (int n = 0; n < NN; n++)
      if (out_sel_q == NW'(n)) f = all_nodes[n];
    f = f ^ out_inv_q;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start)    state_nx = ST_EVAL;
      ST_EVAL: if (word_end) state_nx = ST_OUT;
      ST_OUT:  if (tt_ready) state_nx = last_q ? ST_IDLE : ST_EVAL;
      default:               state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mt        <= '0;
      sh        <= '0;
      tt_data   <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      out_sel_q <= '0;
      out_inv_q <= 1'b0;
      for (int g = 0; g < N_GATES; g++)
        cfg_q[g] <= '0;
    end else begin
      state  <= state_nx;
      done_q <= accept && last_q;
      if (idle) begin
        for (int g = 0; g < N_GATES; g++)
          if (cfg_we && cfg_gate == GW'(g))
            cfg_q[g] <= '{
              sel_a: NW_MAX'(cfg_sel[0 +: NW]),
              sel_b: NW_MAX'(cfg_sel[NW +: NW]),
              sel_c: NW_MAX'(cfg_sel[2*NW +: NW]),
              inv:   cfg_inv
            };
        if (out_we) begin
          out_sel_q <= out_sel;
          out_inv_q <= out_inv;
        end
        if (start) mt <= '0;
      end
      if (state == ST_EVAL) begin
        mt <= mt + 1'b1;
        sh <= {f, sh[WORD_W-2:1]};
        if (word_end) begin
          tt_data <= {f, sh};
          last_q  <= sweep_end;
        end
      end
    end
  end

  assign busy     = !idle;
  assign tt_valid = (state == ST_OUT);
  assign tt_last  = tt_valid && last_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mig_tt_sweeper.sv
// Directed bench for mig_tt_sweeper with hand-computed truth tables.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mig_tt_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_gate;
  logic [11:0] cfg_sel;
  logic [2:0]  cfg_inv;
  logic        out_we;
  logic [3:0]  out_sel;
  logic        out_inv;
  logic        start;
  logic        busy;
  logic [31:0] tt_data;
  logic        tt_valid;
  logic        tt_last;
  logic        tt_ready;
  logic        done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mig_tt_sweeper dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_gate (cfg_gate),
    .cfg_sel  (cfg_sel),
    .cfg_inv  (cfg_inv),
    .out_we   (out_we),
    .out_sel  (out_sel),
    .out_inv  (out_inv),
    .start    (start),
    .busy     (busy),
    .tt_data  (tt_data),
    .tt_valid (tt_valid),
    .tt_last  (tt_last),
    .tt_ready (tt_ready),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gate(input int g, input int a, input int b,
                          input int c, input logic [2:0] inv);
    cfg_we   = 1'b1;
    cfg_gate = 3'(g);
    cfg_sel  = {4'(c), 4'(b), 4'(a)};
    cfg_inv  = inv;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic set_out(input int s, input logic inv);
    out_we  = 1'b1;
    out_sel = 4'(s);
    out_inv = inv;
    tick();
    out_we  = 1'b0;
  endtask

  // Runs one sweep with tt_ready high and gathers words and timing.
  task automatic sweep(input bit do_start,
                       output logic [3:0][31:0] w,
                       output logic [3:0] lst,
                       output int first,
                       output bit gap_ok,
                       output bit to,
                       output bit dn);
    int n;
    int cyc;
    int prev;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n = 0; cyc = 0; prev = 0;
    first = -1; gap_ok = 1'b1; to = 1'b0;
    w = '0; lst = '0;
    while (n < 4 && !to) begin
      if (tt_valid) begin
        w[n]   = tt_data;
        lst[n] = tt_last;
        if (n == 0) first = cyc;
        else if (cyc - prev != 33) gap_ok = 1'b0;
        prev = cyc;
        n++;
      end
      tick();
      cyc++;
      if (cyc > 1000) to = 1'b1;
    end
    dn = !to && done && !busy;
    tick();
    dn = dn && !done;
  endtask

  task automatic check_words(input string name, input logic [3:0][31:0] w,
                             input logic [31:0] exp);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (w[i] !== exp) begin
        fails++;
        $display("FAIL %s word%0d: got %h want %h", name, i, w[i], exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 0; cfg_gate = 0; cfg_sel = 0; cfg_inv = 0;
    out_we = 0; out_sel = 0; out_inv = 0; start = 0; tt_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    tests++;
    if (tt_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", tt_valid);
    end
    tests++;
    if (tt_last !== 1'b0) begin
      fails++; $display("FAIL reset_last: got %b want 0", tt_last);
    end
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL reset_done: got %b want 0", done);
    end
    tests++;
    if (tt_data !== 32'h0) begin
      fails++; $display("FAIL reset_data: got %h want 0", tt_data);
    end
  endtask

  task automatic test_maj();
    logic [3:0][31:0] w;
    logic [3:0] lst;
    int first;
    bit gap_ok, to, dn;
    set_gate(0, 1, 2, 3, 3'b000);
    set_out(8, 1'b0);
    sweep(1'b1, w, lst, first, gap_ok, to, dn);
    check_words("maj", w, 32'hE8E8E8E8);
    tests++;
    if (lst !== 4'b1000) begin
      fails++; $display("FAIL maj_last: got %b want 1000", lst);
    end
    tests++;
    if (first !== 32) begin
      fails++; $display("FAIL maj_latency: got %0d want 32", first);
    end
    tests++;
    if (gap_ok !== 1'b1) begin
      fails++; $display("FAIL maj_gap: got %b want 1", gap_ok);
    end
    tests++;
    if (to !== 1'b0) begin
      fails++; $display("FAIL maj_timeout: got %b want 0", to);
    end
    tests++;
    if (dn !== 1'b1) begin
      fails++; $display("FAIL maj_done: got %b want 1", dn);
    end
  endtask

  task automatic test_out_inv();
    logic [3:0][31:0] w;
    logic [3:0] lst;
    int first;
    bit gap_ok, to, dn;
    out_we = 1'b1; out_sel = 4'd8; out_inv = 1'b1; start = 1'b1;
    tick();
    out_we = 1'b0; start = 1'b0;
    sweep(1'b0, w, lst, first, gap_ok, to, dn);
    check_words("inv", w, 32'h17171717);
    tests++;
    if (lst !== 4'b1000 || to !== 1'b0 || dn !== 1'b1) begin
      fails++;
      $display("FAIL inv_flags: got last=%b to=%b done=%b want 1000 0 1",
               lst, to, dn);
    end
  endtask

  task automatic test_and_or();
    logic [3:0][31:0] w;
    logic [3:0] lst;
    int first;
    bit gap_ok, to, dn;
    set_gate(0, 1, 2, 0, 3'b000);
    set_gate(1, 8, 3, 0, 3'b100);
    set_out(9, 1'b0);
    sweep(1'b1, w, lst, first, gap_ok, to, dn);
    check_words("and_or", w, 32'hF8F8F8F8);
    tests++;
    if (to !== 1'b0 || dn !== 1'b1) begin
      fails++; $display("FAIL and_or_flags: got to=%b done=%b want 0 1", to, dn);
    end
  endtask

  task automatic test_illegal();
    logic [3:0][31:0] w;
    logic [3:0] lst;
    int first;
    bit gap_ok, to, dn;
    set_gate(0, 8, 1, 2, 3'b000);
    set_out(8, 1'b0);
    sweep(1'b1, w, lst, first, gap_ok, to, dn);
    check_words("illegal", w, 32'h88888888);
    tests++;
    if (to !== 1'b0) begin
      fails++; $display("FAIL illegal_timeout: got %b want 0", to);
    end
  endtask

  task automatic test_stall();
    logic [3:0][31:0] w;
    logic [3:0] lst;
    logic [31:0] hold;
    int n, cyc, first;
    bit stalled, stable, gap_ok, to, dn;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; cyc = 0; stalled = 0; stable = 1'b1; w = '0; hold = '0;
    while (n < 4 && cyc < 1000) begin
      if (tt_valid) begin
        if (n == 1 && !stalled) begin
          stalled = 1'b1;
          hold = tt_data;
          tt_ready = 1'b0;
          cfg_we = 1'b1; cfg_gate = 3'd0; cfg_sel = {4'd3, 4'd2, 4'd1};
          cfg_inv = 3'b000;
          out_we = 1'b1; out_sel = 4'd0; out_inv = 1'b1;
          start = 1'b1;
          for (int i = 0; i < 10; i++) begin
            tick();
            cyc++;
            stable = stable && tt_valid && busy && (tt_data === hold);
          end
          cfg_we = 1'b0; out_we = 1'b0; start = 1'b0;
          tt_ready = 1'b1;
        end
        w[n] = tt_data;
        n++;
      end
      tick();
      cyc++;
    end
    tests++;
    if (stalled !== 1'b1 || stable !== 1'b1) begin
      fails++;
      $display("FAIL stall_hold: got stalled=%b stable=%b want 1 1",
               stalled, stable);
    end
    check_words("stall", w, 32'h88888888);
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL stall_done: got %b want 1", done);
    end
    tick();
    sweep(1'b1, w, lst, first, gap_ok, to, dn);
    check_words("post_stall", w, 32'h88888888);
  endtask

  task automatic test_rst_mid();
    logic [3:0][31:0] w;
    logic [3:0] lst;
    int n, cyc, first;
    bit seen, gap_ok, to, dn;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 1000) begin
      if (tt_valid) n++;
      tick();
      cyc++;
    end
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    tests++;
    if ({busy, tt_valid, tt_last, done} !== 4'b0000 || tt_data !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got b/v/l/d=%b data=%h want 0000 0",
               {busy, tt_valid, tt_last, done}, tt_data);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      seen = seen || tt_valid || done || busy;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL rst_mid_quiet: got %b want 0", seen);
    end
    sweep(1'b1, w, lst, first, gap_ok, to, dn);
    check_words("rst_fresh", w, 32'h00000000);
    tests++;
    if (lst !== 4'b1000 || dn !== 1'b1) begin
      fails++;
      $display("FAIL rst_fresh_flags: got last=%b done=%b want 1000 1", lst, dn);
    end
    set_out(8, 1'b0);
    sweep(1'b1, w, lst, first, gap_ok, to, dn);
    check_words("rst_gate_cleared", w, 32'h00000000);
  endtask

  initial begin
    test_reset();
    test_maj();
    test_out_inv();
    test_and_or();
    test_illegal();
    test_stall();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
